// File: rtl/riscv_wb_trace.sv
// riscv_wb_trace: register-file writeback trace buffer.
// Snoops core writebacks, filters them by a programmable mode, and queues
// accepted entries in a first-word-fall-through circular FIFO with overflow
// accounting (sticky flag plus saturating drop counter).
// Optional feature macro: RISCV_TRACE_TS_EN adds a free-running cycle
// counter, a per-entry timestamp and the out_ts port.
module riscv_wb_trace #(
  parameter int unsigned Bits   = 64,
  parameter int unsigned N      = 32,
  parameter int unsigned Depth  = 16,
  parameter int unsigned TsBits = 32,
  localparam int unsigned RW    = $clog2(N),
  localparam int unsigned AW    = $clog2(Depth)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic [RW-1:0]     match_rd,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_rd,
  input  logic [Bits-1:0]   wb_data,
  input  logic [Bits-1:0]   wb_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_rd,
  output logic [Bits-1:0]   out_data,
  output logic [Bits-1:0]   out_pc,
`ifdef RISCV_TRACE_TS_EN
  output logic [TsBits-1:0] out_ts,
`endif
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam logic [AW:0] FullCount = (AW+1)'(Depth);

  // Elaboration-time parameter sanity checks.
  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("Depth must be a power of two >= 2");
  end
  if (TsBits < 1) begin : g_bad_ts
    $error("TsBits must be >= 1");
  end

  logic [RW-1:0]   mem_rd   [Depth];
  logic [Bits-1:0] mem_data [Depth];
  logic [Bits-1:0] mem_pc   [Depth];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic            valid_q;

  logic            mode_hit;
  logic            capture;
  logic            pop;
  logic            full;
  logic            push;
  logic            drop;
  logic [AW:0]     count_next;

  // Capture filter, push/pop/drop decisions and next occupancy.
  always_comb begin
    mode_hit   = 1'b0;
    capture    = 1'b0;
    pop        = 1'b0;
    full       = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    count_next = count;
    unique case (mode)
      2'd0:    mode_hit = 1'b0;
      2'd1:    mode_hit = 1'b1;
      2'd2:    mode_hit = (wb_rd != RW'(0));
      default: mode_hit = (wb_rd == match_rd);
    endcase
    capture    = wb_en && mode_hit;
    pop        = valid_q && out_ready;
    full       = (count == FullCount);
    push       = capture && (!full || pop);
    drop       = capture && full && !pop;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Pointers, occupancy and overflow accounting; rst > clear > push/pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count   <= count_next;
      valid_q <= (count_next != '0);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Entry storage; contents need no reset since out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      mem_rd[wp]   <= wb_rd;
      mem_data[wp] <= wb_data;
      mem_pc[wp]   <= wb_pc;
    end
  end

`ifdef RISCV_TRACE_TS_EN
  logic [TsBits-1:0] ts;
  logic [TsBits-1:0] mem_ts [Depth];

  // Free-running cycle counter; only rst restarts it.
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TsBits'(1);
  end

  // Timestamp of each entry is the counter value at its capture edge.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem_ts[wp] <= ts;
  end

  assign out_ts = mem_ts[rp];
`endif

  // Head entry is presented directly from storage.
  assign out_valid = valid_q;
  assign out_rd    = mem_rd[rp];
  assign out_data  = mem_data[rp];
  assign out_pc    = mem_pc[rp];

endmodule

// File: tb/tb_riscv_wb_trace.sv
// Bench for riscv_wb_trace: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model.
// Honours RISCV_TRACE_TS_EN the same way the design does.
module tb_riscv_wb_trace;

  localparam int unsigned Bits   = 64;
  localparam int unsigned N      = 32;
  localparam int unsigned Depth  = 16;
  localparam int unsigned TsBits = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned AW     = 4;

  logic              clk = 1'b0;
  logic              rst, clear, wb_en, out_ready;
  logic [1:0]        mode;
  logic [RW-1:0]     match_rd, wb_rd;
  logic [Bits-1:0]   wb_data, wb_pc;
  logic              out_valid;
  logic [RW-1:0]     out_rd;
  logic [Bits-1:0]   out_data, out_pc;
  logic [AW:0]       count;
  logic              overflow;
  logic [15:0]       drop_cnt;
`ifdef RISCV_TRACE_TS_EN
  logic [TsBits-1:0] out_ts;
`endif

  riscv_wb_trace #(.Bits(Bits), .N(N), .Depth(Depth), .TsBits(TsBits)) dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .match_rd(match_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_pc(out_pc),
`ifdef RISCV_TRACE_TS_EN
    .out_ts(out_ts),
`endif
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]     rd;
    logic [Bits-1:0]   data;
    logic [Bits-1:0]   pc;
    logic [TsBits-1:0] ts;
  } entry_t;

  entry_t            mq[$];
  int                m_drops;
  bit                m_ovf;
  logic [TsBits-1:0] m_ts;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour for one clock edge, from the pre-edge model state.
  function automatic void model_edge();
    bit cap, popm, was_full;
    entry_t e;
    if (rst) begin
      mq.delete(); m_drops = 0; m_ovf = 0; m_ts = '0;
      return;
    end
    if (clear) begin
      mq.delete(); m_drops = 0; m_ovf = 0; m_ts = m_ts + 1;
      return;
    end
    case (mode)
      2'd0: cap = 0;
      2'd1: cap = wb_en;
      2'd2: cap = wb_en && (wb_rd != 0);
      default: cap = wb_en && (wb_rd == match_rd);
    endcase
    was_full = (mq.size() == Depth);
    popm     = (mq.size() > 0) && out_ready;
    if (popm) void'(mq.pop_front());
    if (cap) begin
      if (!was_full || popm) begin
        e.rd = wb_rd; e.data = wb_data; e.pc = wb_pc; e.ts = m_ts;
        mq.push_back(e);
      end else begin
        if (m_drops < 65535) m_drops++;
        m_ovf = 1;
      end
    end
    m_ts = m_ts + 1;
  endfunction

  // Compare every DUT output against the model.
  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    if (mq.size() != 0) begin
      chk("out_rd", 64'(out_rd), 64'(mq[0].rd));
      chk("out_data", out_data, mq[0].data);
      chk("out_pc", out_pc, mq[0].pc);
`ifdef RISCV_TRACE_TS_EN
      chk("out_ts", 64'(out_ts), 64'(mq[0].ts));
`endif
    end
  endtask

  task automatic step(input logic en, input logic [RW-1:0] rd,
                      input logic [Bits-1:0] data, input logic [Bits-1:0] pc,
                      input logic rdy);
    wb_en = en; wb_rd = rd; wb_data = data; wb_pc = pc; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, rdy);
  endtask

  initial begin
    rst = 1; clear = 0; mode = 0; match_rd = 0; wb_en = 0; wb_rd = 0;
    wb_data = 0; wb_pc = 0; out_ready = 0;
    m_drops = 0; m_ovf = 0; m_ts = '0;
    #2;
    idle(2, 1'b0);
    rst = 0;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);

    // Basic capture and drain.
    mode = 1;
    step(1, 5'd5, 64'h10, 64'h0, 0);
    step(1, 5'd6, 64'h20, 64'h4, 0);
    chk("lit_count2", 64'(count), 64'd2);
    chk("lit_head_rd", 64'(out_rd), 64'd5);
    chk("lit_head_data", out_data, 64'h10);
    idle(1, 1'b1);
    chk("lit_second_rd", 64'(out_rd), 64'd6);
    idle(1, 1'b1);
    chk("lit_drained", 64'(count), 64'd0);

    // Mode 2 rejects x0; mode 3 matches one register.
    mode = 2;
    step(1, 5'd0, 64'h55, 64'h8, 0);
    step(1, 5'd1, 64'hAB, 64'hC, 0);
    chk("lit_mode2_count", 64'(count), 64'd1);
    chk("lit_mode2_data", out_data, 64'hAB);
    idle(1, 1'b1);
    mode = 3; match_rd = 7;
    step(1, 5'd3, 64'h1, 64'h10, 0);
    step(1, 5'd7, 64'h2, 64'h14, 0);
    step(1, 5'd9, 64'h3, 64'h18, 0);
    chk("lit_mode3_count", 64'(count), 64'd1);
    chk("lit_mode3_rd", 64'(out_rd), 64'd7);
    idle(1, 1'b1);

    // Overflow: 20 captures into 16 slots, then full with push+pop.
    mode = 1;
    for (int i = 0; i < 20; i++) step(1, 5'(i + 1), 64'(100 + i), 64'(4 * i), 0);
    chk("lit_full_count", 64'(count), 64'd16);
    chk("lit_full_drops", 64'(drop_cnt), 64'd4);
    chk("lit_full_ovf", 64'(overflow), 64'd1);
    chk("lit_full_head", out_data, 64'd100);
    step(1, 5'd9, 64'd999, 64'h0, 1);
    chk("lit_fullpp_count", 64'(count), 64'd16);
    chk("lit_fullpp_drops", 64'(drop_cnt), 64'd4);

    // Clear with simultaneous capture while count=5, drop_cnt=3.
    clear = 1; idle(1, 1'b0); clear = 0;
    for (int i = 0; i < 19; i++) step(1, 5'd2, 64'(200 + i), 64'h0, 0);
    idle(11, 1'b1);
    chk("lit_pre_clear_count", 64'(count), 64'd5);
    chk("lit_pre_clear_drops", 64'(drop_cnt), 64'd3);
    clear = 1;
    step(1, 5'd4, 64'h77, 64'h0, 0);
    clear = 0;
    chk("lit_clear_count", 64'(count), 64'd0);
    chk("lit_clear_drops", 64'(drop_cnt), 64'd0);
    chk("lit_clear_ovf", 64'(overflow), 64'd0);
    chk("lit_clear_valid", 64'(out_valid), 64'd0);

    // Pointer wrap: fill and drain twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) step(1, 5'(i), 64'(1000 * r + i), 64'(i), 0);
      idle(16, 1'b1);
    end

`ifdef RISCV_TRACE_TS_EN
    // Timestamps relative to reset release.
    rst = 1; idle(1, 1'b0); rst = 0;
    idle(3, 1'b0);
    step(1, 5'd3, 64'h3, 64'h0, 0);
    idle(4, 1'b0);
    step(1, 5'd8, 64'h8, 64'h0, 0);
    chk("lit_ts_first", 64'(out_ts), 64'd3);
    idle(1, 1'b1);
    chk("lit_ts_second", 64'(out_ts), 64'd8);
    idle(1, 1'b1);
`endif

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      mode     = 2'($urandom_range(0, 3));
      match_rd = 5'($urandom_range(0, 7));
      clear    = ($urandom_range(0, 99) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 2) == 0 || i > 2900));
    end
    rst = 0; clear = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_wb_trace.md
# riscv_wb_trace

Parametrised writeback trace buffer for the RISC-V processor. It snoops every register-file writeback (destination register, data, PC) and filters it by a programmable mode. Accepted writebacks go into a circular FIFO of configurable depth, which a testbench or debug port drains over a valid/ready interface. This replaces per-cycle `$monitor` printing of register values with a synthesizable, cycle-accurate record of architectural state changes, with overflow accounting.

## Interface
- Bits, 64, data and PC width
- N, 32, number of architectural registers; RW = $clog2(N)
- Depth, 16, trace entries; power of two, ≥ 2; AW = $clog2(Depth)
- TsBits, 32, timestamp width (used only with the timestamp feature)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of buffer, drop counter and overflow flag
- mode  in  2  0 = off, 1 = all writes, 2 = rd ≠ x0 only, 3 = rd == match_rd only
- match_rd  in  RW  register index compared in mode 3
- wb_en  in  1  writeback strobe from the core
- wb_rd  in  RW  destination register
- wb_data  in  Bits  written value
- wb_pc  in  Bits  PC of the writing instruction
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_rd  out  RW  head entry rd
- out_data  out  Bits  head entry data
- out_pc  out  Bits  head entry PC
- out_ts  out  TsBits  head entry timestamp (port exists only with RISCV_TRACE_TS_EN)
- count  out  AW+1  entries held, 0..Depth
- overflow  out  1  sticky; set when an accepted writeback is dropped
- drop_cnt  out  16  dropped writebacks, saturating at 16'hFFFF

## Operation
- Capture condition: wb_en && the mode predicate. Mode 0 never captures. Mode 2 rejects wb_rd == 0. Mode 3 requires wb_rd == match_rd.
- Storage: Depth-entry memory, write pointer wp and read pointer rp, both AW bits wide and wrapping modulo Depth. count is tracked separately.
- Push: the capture is written at mem[wp]; wp increments.
- Pop: out_valid && out_ready at a clock edge; rp increments.
- First-word-fall-through: out_rd/out_data/out_pc/out_ts always show mem[rp]. Their values are don't-care while out_valid = 0. out_valid = (count ≠ 0).
- Full (count == Depth) and capture without a simultaneous pop: the new entry is dropped, not the oldest. drop_cnt increments (saturating) and overflow sets.
- Full with simultaneous capture and pop: both occur. count stays Depth, no drop.
- Empty with simultaneous capture and out_ready: no pop occurs (out_valid was 0); the push is accepted.
- clear: wp = rp = count = 0, overflow = 0, drop_cnt = 0. A capture in the same cycle is discarded and is not counted as a drop. The timestamp is unaffected.
- Priority per edge: rst > clear > push/pop.
- A change of mode takes effect on the next writeback sampled; entries already stored are unaffected.

## Timing
- Reset values: out_valid = 0, count = 0, overflow = 0, drop_cnt = 0, out_rd/out_data/out_pc/out_ts are don't-care, internal pointers = 0, timestamp = 0.
- Capture latency is 1 cycle: a writeback sampled at edge k gives out_valid = 1 after edge k.
- Back-to-back throughput: one push and one pop per cycle.
- count, overflow and drop_cnt are registered. They update at the same edge as the push or pop that changes them.
- Reset asserted mid-operation empties the buffer at that edge; stored contents are lost.

## Configuration
- RISCV_TRACE_TS_EN defined:
  - A free-running TsBits-bit cycle counter runs, cleared only by rst and wrapping to 0 after all-ones.
  - Each entry stores the counter value at its capture edge; out_ts presents the head entry's value.
- RISCV_TRACE_TS_EN undefined:
  - No counter, no timestamp storage, and no out_ts port.
  - All other behaviour is identical.

## Test plan
- Reset, then mode = 1 and writebacks (x5, 0x10, pc 0x0), (x6, 0x20, pc 0x4) with out_ready = 0 → count = 2, head = x5/0x10. Pull out_ready high for 2 cycles → x5 then x6 delivered, count = 0.
- mode = 2, writebacks to x0 then x1 = 0xAB → only x1 captured, count = 1. mode = 3 with match_rd = 7, writebacks to x3, x7, x9 → only x7 captured.
- Depth = 16, out_ready = 0, 20 captures → count = 16, drop_cnt = 4, overflow = 1, head is the first capture. Full plus simultaneous capture and pop → count stays 16, drop_cnt stays 4.
- 16 captures followed by 16 pops, repeated twice → pointers wrap and data order is preserved across the wrap.
- clear asserted together with a capture while count = 5 and drop_cnt = 3 → next cycle count = 0, drop_cnt = 0, overflow = 0, out_valid = 0.
- With RISCV_TRACE_TS_EN: capture at cycles 3 and 8 after reset release → out_ts = 3 then 8. rst mid-stream → the counter restarts at 0.
